snitch_ssr_cfg_queue: RTL and testbench
=======================================

Name: snitch_ssr_cfg_queue

Overview:
- Buffered configuration front-end for a generalised, NumSsrs-wide SSR streamer.
- Accepts core config writes into a parametrised FIFO and decodes the upper address into a single-SSR or broadcast target.
- Retires each write only when every targeted data mover signals wready, so the core is not stalled on shadowed jobs.
- Reads are ordered behind all pending writes and return data with a registered response.

Parameters:
- NumSsrs, 3, number of data movers served (1..31).
- Depth, 4, write-queue entries (power of two, >=2).
- WordWidth, 5, word-select field width forwarded to data movers.
- SelLsb, 7, LSB of the 5-bit SSR-select field inside cfg_word_i.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cfg_word_i  in  12  config address; [SelLsb+4:SelLsb] = SSR select, [WordWidth-1:0] = word
- cfg_write_i  in  1  1 = write, 0 = read
- cfg_wdata_i  in  32  write data
- cfg_valid_i  in  1  request valid
- cfg_ready_o  out  1  request accepted
- cfg_rdata_o  out  32  read data
- cfg_rvalid_o  out  1  read response valid, one-cycle pulse
- pending_o  out  $clog2(Depth+1)  queued write count
- dm_word_o  out  WordWidth  word of head entry / read
- dm_wdata_o  out  32  data of head entry
- dm_write_o  out  NumSsrs  one-cycle write strobe per mover
- dm_wready_i  in  NumSsrs  mover can take a write
- dm_rdata_i  in  NumSsrs*32  mover read data

Behaviour:
- Reset (async, rst_i=1): FIFO empty, pointers 0, read FSM IDLE.
  - Outputs at reset: cfg_ready_o=1, cfg_rvalid_o=0, cfg_rdata_o=0, dm_write_o=0, pending_o=0.
- Target decode: sel=cfg_word_i[SelLsb+4:SelLsb].
  - sel==5'h1F: broadcast, mask = all ones.
  - sel<NumSsrs: mask = 1<<sel.
  - Otherwise: invalid, mask = 0.
  - The mask is computed and stored at enqueue.
- Write enqueue: occurs on cfg_valid_i & cfg_write_i & cfg_ready_o; stores {mask, word, data}.
  - For writes, cfg_ready_o = !full.
  - No enqueue-while-full even if a pop occurs in the same cycle; this avoids a combinational path from dm_wready_i to cfg_ready_o.
- Write retire:
  - Head is non-empty and (dm_wready_i & mask)==mask → dm_write_o=mask for exactly that cycle, dm_word_o/dm_wdata_o = head fields, then pop.
  - mask==0 → popped in one cycle with no strobe (dropped).
  - Head is never strobed partially; a broadcast waits for all movers.
  - dm_write_o is combinational from the head entry and dm_wready_i; it is 0 when the queue is empty.
  - Throughput: one retire per cycle.
  - Minimum latency from accept to strobe: 1 cycle (entry is registered).
- pending_o: occupancy count; +1 on enqueue, -1 on pop, unchanged when both occur in the same cycle.
- Read FSM (IDLE, RESP):
  - IDLE, read request: cfg_ready_o = empty (write ordering). On accept, latch sel and word and go to RESP.
  - RESP: cfg_rdata_o = dm_rdata_i[sel] if sel<NumSsrs, else 0; cfg_rvalid_o=1 for one cycle, then IDLE.
  - In RESP, cfg_ready_o=0 for all requests.
  - dm_word_o shows the latched read word in RESP; otherwise it shows the head word.
  - Read of broadcast sel returns 0.
  - cfg_rdata_o is held from the last response while cfg_rvalid_o=0.
- Simultaneous events:
  - A read arriving while writes are pending stalls until the last pop completes; the read is accepted in the cycle after the queue becomes empty.
  - Enqueue at empty and retire do not both act on the same entry in one cycle.
- Reset mid-operation: queued writes are discarded; no strobe is issued after reset asserts.
- Wrap-around: pointers are log2(Depth)+1 bits.
  - full when MSBs differ and the rest match.
  - empty when the pointers are equal.

Optional Feature:
- Macro: SNITCH_SSR_CFGQ_ERR_EN
- When defined, adds output err_o (1 bit).
  - Sticky, set in the cycle an invalid-target write is popped or an out-of-range read is answered.
  - Cleared only by reset or by a write to sel=5'h1E, word=0. That write is consumed by the block and never strobed.
- When undefined: no err_o port, invalid writes are dropped silently, and sel=5'h1E is treated as an ordinary invalid target.

Test Plan:
- Write sel=1, word=3, data=0xDEAD_BEEF with dm_wready_i=3'b111 → dm_write_o=3'b010 exactly 1 cycle after accept; dm_word_o=3; dm_wdata_o=0xDEADBEEF; pending_o returns to 0.
- Broadcast write (sel=0x1F) with dm_wready_i=3'b101 for 5 cycles, then 3'b111 → no strobe for 5 cycles, then dm_write_o=3'b111 for one cycle.
- Depth=4: 5 back-to-back writes with dm_wready_i=0 → first 4 accepted, cfg_ready_o=0 on the 5th, pending_o=4; raising wready drains one entry per cycle, in order.
- Read sel=2 with 2 writes pending → read stalls until pending_o=0, then cfg_rvalid_o pulses the following cycle with dm_rdata_i[2]; a write to sel=5 (NumSsrs=3) is dropped without strobe.
- Assert rst_i with 3 entries queued and RESP active → next cycle dm_write_o=0, pending_o=0, cfg_rvalid_o=0, cfg_ready_o=1.
- With SNITCH_SSR_CFGQ_ERR_EN: write sel=6 → err_o=1 sticky; write sel=0x1E, word=0 → err_o=0 and no dm_write_o strobe.

Source files
------------

// File: rtl/snitch_ssr_cfg_queue.sv
// SSR config front-end: queues core config writes and fans them out to NumSsrs data movers.
// Latency: a write strobes its movers 1 cycle after accept at the earliest; reads answer 1 cycle after accept.
// Backpressure: writes stall while the queue is full; reads stall until the queue has drained.
// Optional build macro SNITCH_SSR_CFGQ_ERR_EN adds the sticky err_o flag and the sel=5'h1E/word=0 clear write.

// Generic occupancy-counting FIFO with extra-MSB wrap pointers.
// Latency: an entry becomes visible at the head one cycle after push.
// Backpressure: push ignored while full, pop ignored while empty.
module snitch_ssr_cfg_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    localparam int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_vld,
    input  logic [DataWidth-1:0] push_dat,
    input  logic                 pop_vld,
    output logic [DataWidth-1:0] head_dat,
    output logic                 full,
    output logic                 empty,
    output logic [AddrWidth:0]   count
);
    logic [AddrWidth:0]   wptr_q, rptr_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 do_push, do_pop;

    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AddrWidth] != rptr_q[AddrWidth]) &&
                      (wptr_q[AddrWidth-1:0] == rptr_q[AddrWidth-1:0]);
    assign count    = wptr_q - rptr_q;
    assign head_dat = mem_q[rptr_q[AddrWidth-1:0]];

    // Read/write pointers; reset discards every queued entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AddrWidth-1:0]] <= push_dat;
    end
endmodule

// Config queue top: decodes SSR target at enqueue, retires head only when all targets are ready.
// Latency: strobe >= 1 cycle after write accept; read response exactly 1 cycle after read accept.
// Backpressure: cfg_ready_o = !full for writes, = empty for reads, 0 while a read response is out.
module snitch_ssr_cfg_queue #(
    parameter int unsigned NumSsrs   = 3,
    parameter int unsigned Depth     = 4,
    parameter int unsigned WordWidth = 5,
    parameter int unsigned SelLsb    = 7
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [11:0]                cfg_word_i,
    input  logic                       cfg_write_i,
    input  logic [31:0]                cfg_wdata_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic [31:0]                cfg_rdata_o,
    output logic                       cfg_rvalid_o,
    output logic [$clog2(Depth+1)-1:0] pending_o,
    output logic [WordWidth-1:0]       dm_word_o,
    output logic [31:0]                dm_wdata_o,
    output logic [NumSsrs-1:0]         dm_write_o,
    input  logic [NumSsrs-1:0]         dm_wready_i,
`ifdef SNITCH_SSR_CFGQ_ERR_EN
    output logic                       err_o,
`endif
    input  logic [NumSsrs*32-1:0]      dm_rdata_i
);
    typedef struct packed {
`ifdef SNITCH_SSR_CFGQ_ERR_EN
        logic                 clr;
`endif
        logic [NumSsrs-1:0]   mask;
        logic [WordWidth-1:0] word;
        logic [31:0]          data;
    } entry_t;

    typedef enum logic {IDLE, RESP} rd_state_e;

    rd_state_e            state_q, state_d;
    entry_t               enq_entry, head;
    logic [4:0]           sel;
    logic                 push, pop, full, empty, rd_acc;
    logic [4:0]           rd_sel_q;
    logic [WordWidth-1:0] rd_word_q;
    logic [31:0]          rd_data, rdata_q;
    logic                 rd_in_range;
    logic                 unused_word_bits;

    // Only the select and word fields of the address are decoded.
    assign unused_word_bits = ^cfg_word_i;
    assign sel = cfg_word_i[SelLsb+4 -: 5];

    // Target decode at enqueue: broadcast, single mover, or invalid (empty mask).
    always_comb begin
        enq_entry      = '0;
        enq_entry.word = cfg_word_i[WordWidth-1:0];
        enq_entry.data = cfg_wdata_i;
        if (sel == 5'h1F) begin
            enq_entry.mask = '1;
        end else begin
            for (int i = 0; i < int'(NumSsrs); i++) begin
                if (sel == 5'(i)) enq_entry.mask[i] = 1'b1;
            end
        end
`ifdef SNITCH_SSR_CFGQ_ERR_EN
        // The error-clear write rides the queue to stay ordered, but never strobes a mover.
        if (sel == 5'h1E && cfg_word_i[WordWidth-1:0] == '0) begin
            enq_entry.clr  = 1'b1;
            enq_entry.mask = '0;
        end
`endif
    end

    snitch_ssr_cfg_fifo #(
        .DataWidth ($bits(entry_t)),
        .Depth     (Depth)
    ) i_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (push),
        .push_dat (enq_entry),
        .pop_vld  (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (pending_o)
    );

    // Head retires only when every targeted mover is ready; an empty mask retires at once.
    assign pop        = !empty && ((dm_wready_i & head.mask) == head.mask);
    assign dm_write_o = pop ? head.mask : '0;
    assign dm_wdata_o = head.data;
    assign dm_word_o  = (state_q == RESP) ? rd_word_q : head.word;
    assign push       = cfg_valid_i && cfg_write_i && cfg_ready_o;

    // Read FSM next state and handshake; reads wait for the write queue to drain.
    always_comb begin
        state_d      = state_q;
        cfg_ready_o  = 1'b0;
        cfg_rvalid_o = 1'b0;
        rd_acc       = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = cfg_write_i ? !full : empty;
                if (cfg_valid_i && !cfg_write_i && empty) begin
                    rd_acc  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cfg_rvalid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Select the addressed mover's read data; broadcast and out-of-range selects read as 0.
    always_comb begin
        rd_data     = '0;
        rd_in_range = 1'b0;
        for (int i = 0; i < int'(NumSsrs); i++) begin
            if (rd_sel_q == 5'(i)) begin
                rd_data     = dm_rdata_i[i*32 +: 32];
                rd_in_range = 1'b1;
            end
        end
    end

    // Latch read target on accept and hold the last response data between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_sel_q  <= '0;
            rd_word_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (rd_acc) begin
                rd_sel_q  <= sel;
                rd_word_q <= cfg_word_i[WordWidth-1:0];
            end
            if (state_q == RESP) rdata_q <= rd_data;
        end
    end

    assign cfg_rdata_o = (state_q == RESP) ? rd_data : rdata_q;

`ifdef SNITCH_SSR_CFGQ_ERR_EN
    logic err_q;

    // Sticky error: set on a dropped invalid write or an out-of-range read, cleared by the clear write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (pop && head.clr) begin
            err_q <= 1'b0;
        end else if ((pop && head.mask == '0) || (state_q == RESP && !rd_in_range)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_snitch_ssr_cfg_queue.sv
module tb_snitch_ssr_cfg_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cfg_word = '0;
    logic        cfg_write = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] cfg_rdata_o;
    logic        cfg_rvalid_o;
    logic [2:0]  pending_o;
    logic [4:0]  dm_word_o;
    logic [31:0] dm_wdata_o;
    logic [2:0]  dm_write_o;
    logic [2:0]  dm_wready = '0;
    logic [95:0] dm_rdata = '0;
`ifdef SNITCH_SSR_CFGQ_ERR_EN
    logic        err_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snitch_ssr_cfg_queue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_word_i   (cfg_word),
        .cfg_write_i  (cfg_write),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .cfg_rvalid_o (cfg_rvalid_o),
        .pending_o    (pending_o),
        .dm_word_o    (dm_word_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_write_o   (dm_write_o),
        .dm_wready_i  (dm_wready),
`ifdef SNITCH_SSR_CFGQ_ERR_EN
        .err_o        (err_o),
`endif
        .dm_rdata_i   (dm_rdata)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0h want 1", cfg_ready_o); end
        checks++; if (cfg_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %0h want 0", cfg_rvalid_o); end
        checks++; if (cfg_rdata_o !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %0h want 0", cfg_rdata_o); end
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL reset_strobe: got %0h want 0", dm_write_o); end
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL reset_pending: got %0h want 0", pending_o); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_write;
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'h083; cfg_wdata = 32'hDEAD_BEEF; dm_wready = 3'b111;
        #1;
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL single_ready: got %0h want 1", cfg_ready_o); end
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (dm_write_o !== 3'b010) begin failures++; $display("FAIL single_strobe: got %0h want 2", dm_write_o); end
        checks++; if (dm_word_o !== 5'd3) begin failures++; $display("FAIL single_word: got %0h want 3", dm_word_o); end
        checks++; if (dm_wdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_wdata: got %0h want deadbeef", dm_wdata_o); end
        checks++; if (pending_o !== 3'd1) begin failures++; $display("FAIL single_pending1: got %0h want 1", pending_o); end
        step();
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL single_one_shot: got %0h want 0", dm_write_o); end
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL single_pending0: got %0h want 0", pending_o); end
    endtask

    task automatic test_broadcast;
        dm_wready = 3'b101;
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'hF80; cfg_wdata = 32'h1234_5678;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL bcast_wait%0d: got %0h want 0", i, dm_write_o); end
            step();
        end
        dm_wready = 3'b111;
        #1;
        checks++; if (dm_write_o !== 3'b111) begin failures++; $display("FAIL bcast_strobe: got %0h want 7", dm_write_o); end
        checks++; if (dm_wdata_o !== 32'h1234_5678) begin failures++; $display("FAIL bcast_wdata: got %0h want 12345678", dm_wdata_o); end
        step();
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL bcast_one_shot: got %0h want 0", dm_write_o); end
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL bcast_pending: got %0h want 0", pending_o); end
    endtask

    task automatic test_back_to_back;
        logic exp_rdy;
        dm_wready = 3'b000;
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_write = 1'b1;
            cfg_word  = 12'(((i % 3) << 7) | i);
            cfg_wdata = 32'h100 + 32'(i);
            exp_rdy   = (i < 4);
            #1;
            checks++; if (cfg_ready_o !== exp_rdy) begin failures++; $display("FAIL full_ready%0d: got %0h want %0h", i, cfg_ready_o, exp_rdy); end
            step();
        end
        cfg_valid = 1'b0;
        #1;
        checks++; if (pending_o !== 3'd4) begin failures++; $display("FAIL full_pending: got %0h want 4", pending_o); end
        dm_wready = 3'b111;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++; if (dm_write_o !== 3'(1 << (j % 3))) begin failures++; $display("FAIL drain_strobe%0d: got %0h want %0h", j, dm_write_o, 3'(1 << (j % 3))); end
            checks++; if (dm_wdata_o !== 32'h100 + 32'(j)) begin failures++; $display("FAIL drain_wdata%0d: got %0h want %0h", j, dm_wdata_o, 32'h100 + 32'(j)); end
            checks++; if (dm_word_o !== 5'(j)) begin failures++; $display("FAIL drain_word%0d: got %0h want %0h", j, dm_word_o, j); end
            step();
        end
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL drain_pending: got %0h want 0", pending_o); end
    endtask

    task automatic test_read_order;
        dm_wready = 3'b000;
        dm_rdata  = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};
        for (int i = 1; i <= 2; i++) begin
            cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'(i); cfg_wdata = 32'(i);
            step();
        end
        cfg_write = 1'b0; cfg_word = 12'h107;
        #1;
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rd_stall0: got %0h want 0", cfg_ready_o); end
        step();
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rd_stall1: got %0h want 0", cfg_ready_o); end
        dm_wready = 3'b111;
        #1;
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rd_stall2: got %0h want 0", cfg_ready_o); end
        step();
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rd_stall3: got %0h want 0", cfg_ready_o); end
        step();
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL rd_drained: got %0h want 0", pending_o); end
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL rd_accept: got %0h want 1", cfg_ready_o); end
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (cfg_rvalid_o !== 1'b1) begin failures++; $display("FAIL rd_rvalid: got %0h want 1", cfg_rvalid_o); end
        checks++; if (cfg_rdata_o !== 32'hCCCC_2222) begin failures++; $display("FAIL rd_rdata: got %0h want cccc2222", cfg_rdata_o); end
        checks++; if (dm_word_o !== 5'd7) begin failures++; $display("FAIL rd_word: got %0h want 7", dm_word_o); end
        checks++; if (cfg_ready_o !== 1'b0) begin failures++; $display("FAIL rd_resp_busy: got %0h want 0", cfg_ready_o); end
        step();
        checks++; if (cfg_rvalid_o !== 1'b0) begin failures++; $display("FAIL rd_pulse: got %0h want 0", cfg_rvalid_o); end
        checks++; if (cfg_rdata_o !== 32'hCCCC_2222) begin failures++; $display("FAIL rd_hold: got %0h want cccc2222", cfg_rdata_o); end
        // Broadcast-select read answers 0.
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_word = 12'hF85;
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (cfg_rvalid_o !== 1'b1) begin failures++; $display("FAIL rd_bcast_rvalid: got %0h want 1", cfg_rvalid_o); end
        checks++; if (cfg_rdata_o !== 32'h0) begin failures++; $display("FAIL rd_bcast_rdata: got %0h want 0", cfg_rdata_o); end
        step();
        // Write to sel=5 is out of range and must vanish without a strobe.
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'h281; cfg_wdata = 32'h0000_0BAD;
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL inv_strobe: got %0h want 0", dm_write_o); end
        checks++; if (pending_o !== 3'd1) begin failures++; $display("FAIL inv_pending1: got %0h want 1", pending_o); end
        step();
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL inv_dropped: got %0h want 0", pending_o); end
    endtask

    task automatic test_reset_midop;
        dm_wready = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'h000; cfg_wdata = 32'(i);
            step();
        end
        cfg_valid = 1'b0;
        #1;
        checks++; if (pending_o !== 3'd3) begin failures++; $display("FAIL mid_pending3: got %0h want 3", pending_o); end
        dm_wready = 3'b111;
        rst = 1'b1;
        #1;
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL mid_strobe: got %0h want 0", dm_write_o); end
        checks++; if (pending_o !== 3'd0) begin failures++; $display("FAIL mid_pending: got %0h want 0", pending_o); end
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL mid_ready: got %0h want 1", cfg_ready_o); end
        step();
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL mid_strobe_next: got %0h want 0", dm_write_o); end
        rst = 1'b0;
        step();
        // Reset while a read response is being presented.
        cfg_valid = 1'b1; cfg_write = 1'b0; cfg_word = 12'h080;
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (cfg_rdata_o !== 32'hBBBB_1111) begin failures++; $display("FAIL mid_resp_rdata: got %0h want bbbb1111", cfg_rdata_o); end
        rst = 1'b1;
        #1;
        checks++; if (cfg_rvalid_o !== 1'b0) begin failures++; $display("FAIL mid_rvalid: got %0h want 0", cfg_rvalid_o); end
        checks++; if (cfg_rdata_o !== 32'h0) begin failures++; $display("FAIL mid_rdata: got %0h want 0", cfg_rdata_o); end
        checks++; if (cfg_ready_o !== 1'b1) begin failures++; $display("FAIL mid_ready_resp: got %0h want 1", cfg_ready_o); end
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef SNITCH_SSR_CFGQ_ERR_EN
    task automatic test_err;
        dm_wready = 3'b111;
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'h300; cfg_wdata = 32'h0;
        step();
        cfg_valid = 1'b0;
        step();
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set: got %0h want 1", err_o); end
        step();
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0h want 1", err_o); end
        cfg_valid = 1'b1; cfg_write = 1'b1; cfg_word = 12'hF00;
        step();
        cfg_valid = 1'b0;
        #1;
        checks++; if (dm_write_o !== 3'b000) begin failures++; $display("FAIL err_clr_strobe: got %0h want 0", dm_write_o); end
        step();
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_clear: got %0h want 0", err_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_broadcast();
        test_back_to_back();
        test_read_order();
        test_reset_midop();
`ifdef SNITCH_SSR_CFGQ_ERR_EN
        test_err();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
